spi_master_param: RTL and testbench

- Parametrised successor to the single-mode, fixed-width `spi` block.
- Full-duplex SPI master with configurable word width, SCLK divider and chip-select count.
- Per-transfer runtime selection of CPOL, CPHA, bit order and target slave.
- Sits between a local request/response interface (start/tx_data in, done/rx_data out) and the SPI pins.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_clk_div.sv | 44 ++++
 rtl/spi_master_param.sv | 195 +++++++++++++++++++
 tb/tb_spi_master_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the parametrised SPI master.
//               - state_t      : transfer sequencer states
//               - MODE0..MODE3 : SPI mode encodings as {cpol, cpha}
//               - clog2_min1   : ceil(log2(n)) clamped to a minimum of 1
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD     = 3'd1,
    TRANSFER = 3'd2,
    TRAIL    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Width of a field able to index n items; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : SCLK half-period timer. Counts 0..CLK_DIV-1 while enabled and
//               pulses tick on the last count; held at zero when disabled so
//               every transfer starts from a fresh half-period.
// Ports       : clk    - system clock
//               reset  - asynchronous active-low reset
//               enable - count while high, clear while low
//               tick   - one-cycle pulse marking the end of a half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int                CNT_W  = clog2_min1(CLK_DIV);
  localparam logic [CNT_W-1:0]  C_WRAP = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == C_WRAP);
  assign tick   = enable && w_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!enable || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_param
// Description : Full-duplex SPI master with parametrised word width, SCLK
//               divider and chip-select count. CPOL, CPHA, bit order and
//               target slave are latched per transfer on an accepted start.
// Ports       : clk, reset (async active-low)
//               start, tx_data, cs_sel, cpol, cpha, lsb_first - request side
//               busy, done, rx_data                          - response side
//               sclk, mosi, miso, chip_select_n              - SPI pins
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 2,
  parameter int CLK_DIV = 2,
  // Derived from NUM_CS; leave at its default.
  parameter int CS_W    = clog2_min1(NUM_CS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] chip_select_n
);

  localparam int                EDGE_W      = clog2_min1(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] C_LAST_EDGE = EDGE_W'(2 * DATA_W);

  state_t              r_state;
  state_t              w_next;
  logic                w_tick;
  logic                w_accept;
  logic                w_busy;

  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_data;
  logic [EDGE_W-1:0]   r_edge_cnt;
  logic                r_cpha;
  logic                r_lsb;
  logic                r_sclk;
  logic                r_mosi;
  logic [NUM_CS-1:0]   r_cs_n;

  logic [EDGE_W-1:0]   w_edge;
  logic                w_last_edge;
  logic [DATA_W-1:0]   w_tx_src;
  logic                w_src_lsb;
  logic                w_tx_bit;
  logic [DATA_W-1:0]   w_tx_shift;
  logic [NUM_CS-1:0]   w_cs_dec;

  // DONE behaves like IDLE for start so back-to-back words need no gap
  // beyond the single DONE cycle.
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .reset  (reset),
    .enable (w_busy),
    .tick   (w_tick)
  );

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = LEAD;
      end
      LEAD: begin
        w_busy = 1'b1;
        if (w_tick) w_next = TRANSFER;
      end
      TRANSFER: begin
        w_busy = 1'b1;
        if (w_tick && w_last_edge) w_next = TRAIL;
      end
      TRAIL: begin
        w_busy = 1'b1;
        if (w_tick) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? LEAD : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = w_busy;

  // --------------------------------------------------------------------------
  // Shift / sample datapath
  // --------------------------------------------------------------------------
  // Edge number (1-based) of the SCLK edge produced by the current tick;
  // odd numbers are leading edges.
  assign w_edge      = r_edge_cnt + EDGE_W'(1);
  assign w_last_edge = (w_edge == C_LAST_EDGE);

  // On an accepted start the first bit comes straight from tx_data so that
  // CPHA=0 has it on MOSI from the moment chip select falls.
  assign w_tx_src   = w_accept ? tx_data   : r_tx;
  assign w_src_lsb  = w_accept ? lsb_first : r_lsb;
  assign w_tx_bit   = w_src_lsb ? w_tx_src[0] : w_tx_src[DATA_W-1];
  assign w_tx_shift = w_src_lsb ? (w_tx_src >> 1) : (w_tx_src << 1);

  // Out-of-range cs_sel matches nothing, leaving all selects high.
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) w_cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_edge_cnt <= '0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= '1;
    end else if (w_accept) begin
      // r_sclk doubles as the latched CPOL: it always returns to it.
      r_sclk     <= cpol;
      r_cpha     <= cpha;
      r_lsb      <= lsb_first;
      r_cs_n     <= w_cs_dec;
      r_tx       <= cpha ? tx_data : w_tx_shift;
      r_mosi     <= cpha ? 1'b0    : w_tx_bit;
      r_rx       <= '0;
      r_edge_cnt <= '0;
    end else if (w_tick) begin
      case (r_state)
        TRANSFER: begin
          r_sclk     <= ~r_sclk;
          r_edge_cnt <= w_edge;
          // CPHA=0 samples on leading (odd) edges, CPHA=1 on trailing ones;
          // the other edge type launches the next bit, except the final
          // trailing edge of CPHA=0 which has nothing left to send.
          if (w_edge[0] != r_cpha) begin
            r_rx <= r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
          end else if (!w_last_edge) begin
            r_mosi <= w_tx_bit;
            r_tx   <= w_tx_shift;
          end
        end
        TRAIL: begin
          r_cs_n    <= '1;
          r_mosi    <= 1'b0;
          r_rx_data <= r_rx;
        end
        default: ;
      endcase
    end
  end

  assign sclk          = r_sclk;
  assign mosi          = r_mosi;
  assign chip_select_n = r_cs_n;
  assign rx_data       = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_param
// Description : Directed self-checking bench. Two instances: an 8-bit,
//               CLK_DIV=2, NUM_CS=2 master (loopback or SPI slave model on
//               MISO) and a 16-bit, CLK_DIV=1, NUM_CS=3 master in loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_param;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tx_data;
  logic [1:0]  cs_sel;
  logic        cpol, cpha, lsb_first;
  logic        start8, start16;
  logic        loop;
  logic        sel;

  logic        busy8, done8, sclk8, mosi8, miso8;
  logic [7:0]  rx8;
  logic [1:0]  csn8;
  logic        busy16, done16, sclk16, mosi16, miso16;
  logic [15:0] rx16;
  logic [2:0]  csn16;

  logic        m_busy, m_done, m_sclk, m_mosi;
  logic [15:0] m_rx;
  logic [2:0]  m_cs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_CS(2), .CLK_DIV(2)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .tx_data(tx_data[7:0]),
    .cs_sel(cs_sel[0]), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .busy(busy8), .done(done8), .rx_data(rx8), .sclk(sclk8), .mosi(mosi8),
    .miso(miso8), .chip_select_n(csn8)
  );

  spi_master_param #(.DATA_W(16), .NUM_CS(3), .CLK_DIV(1)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .tx_data(tx_data),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .busy(busy16), .done(done16), .rx_data(rx16), .sclk(sclk16), .mosi(mosi16),
    .miso(miso16), .chip_select_n(csn16)
  );

  assign m_busy = sel ? busy16 : busy8;
  assign m_done = sel ? done16 : done8;
  assign m_sclk = sel ? sclk16 : sclk8;
  assign m_mosi = sel ? mosi16 : mosi8;
  assign m_rx   = sel ? rx16   : {8'h00, rx8};
  assign m_cs   = sel ? csn16  : {1'b1, csn8};

  // --------------------------------------------------------------------------
  // SPI slave model on chip select 0 of the 8-bit master, MSB first.
  // --------------------------------------------------------------------------
  logic [7:0] slv_word  = 8'h3C;
  int         slv_edges = 0;
  logic       slv_miso  = 1'b0;

  assign miso8  = loop ? mosi8 : slv_miso;
  assign miso16 = mosi16;

  always @(negedge csn8[0]) begin
    slv_edges = 0;
    slv_miso  = cpha ? 1'b0 : slv_word[7];
  end

  // The SCLK move to the new CPOL coincides with CS falling; it is not a
  // data edge and is skipped.
  always @(sclk8) begin
    if (!csn8[0] && !(slv_edges == 0 && sclk8 == cpol)) begin
      slv_edges++;
      if (!cpha && (slv_edges % 2 == 0) && slv_edges < 16)
        slv_miso = slv_word[7 - slv_edges / 2];
      if (cpha && (slv_edges % 2 == 1) && slv_edges < 16)
        slv_miso = slv_word[7 - (slv_edges - 1) / 2];
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request and returns at the negedge after the accepting edge.
  task automatic go(input logic s, input logic [15:0] tx, input logic [1:0] cs,
                    input logic [1:0] mode, input logic lsb, input logic hold);
    @(negedge clk);
    sel       = s;
    tx_data   = tx;
    cs_sel    = cs;
    {cpol, cpha} = mode;
    lsb_first = lsb;
    if (s) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start8  = 1'b0;
      start16 = 1'b0;
    end
  endtask

  // Waits (bounded) for done. lat counts cycles from the accept cycle, so the
  // accept cycle is t0 and the first call point is t0+1.
  task automatic wait_done(input logic repulse, output int lat, output int rises,
                           output logic [15:0] mbits, output logic [2:0] cs_mid,
                           output logic sclk_lead, output logic [2:0] cs_and);
    logic prev;
    lat       = 1;
    rises     = 0;
    mbits     = '0;
    cs_mid    = '1;
    cs_and    = m_cs;
    sclk_lead = m_sclk;
    prev      = m_sclk;
    while (!m_done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (m_sclk != prev) begin
        if (m_sclk) rises++;
        // capture MOSI on the edge where the slave would sample it
        if ((m_sclk != cpol) == !cpha) mbits = {mbits[14:0], m_mosi};
      end
      prev   = m_sclk;
      cs_and = cs_and & m_cs;
      if (lat == 10) cs_mid = m_cs;
      if (repulse && lat == 10) begin
        tx_data = 16'hFFFF;
        start8  = 1'b1;
      end
      if (repulse && lat == 11) start8 = 1'b0;
    end
    chk("done_seen", {31'd0, m_done}, 32'd1);
  endtask

  task automatic quiet(input int n, output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_busy) nb++;
      if (m_done) nd++;
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int          lat, rises, nb, nd;
    logic [15:0] mbits;
    logic [2:0]  cs_mid, cs_and;
    logic        sclk_lead;
    logic [1:0]  mode;

    reset = 1'b0; start8 = 1'b0; start16 = 1'b0; tx_data = '0; cs_sel = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_rx",   {24'd0, rx8},   32'd0);
    chk("rst_sclk", {31'd0, sclk8}, 32'd0);
    chk("rst_mosi", {31'd0, mosi8}, 32'd0);
    chk("rst_csn",  {30'd0, csn8},  32'h3);
    chk("rst_csn16", {29'd0, csn16}, 32'h7);
    reset = 1'b1;
    @(negedge clk);

    // Mode 0 loopback, 0xA5 to slave 0
    go(1'b0, 16'h00A5, 2'd0, MODE0, 1'b0, 1'b0);
    wait_done(1'b0, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
    chk("m0_latency", 32'(lat), 32'd37);
    chk("m0_rx", {16'd0, m_rx}, 32'hA5);
    chk("m0_cs", {29'd0, cs_mid}, 32'h6);
    chk("m0_rises", 32'(rises), 32'd8);
    chk("m0_mosi_bits", {24'd0, mbits[7:0]}, 32'hA5);

    // Modes 1..3 against the slave model
    loop = 1'b0;
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      go(1'b0, 16'h0096, 2'd0, mode, 1'b0, 1'b0);
      wait_done(1'b0, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
      chk($sformatf("mode%0d_rx", m), {16'd0, m_rx}, 32'h3C);
      chk($sformatf("mode%0d_sclk_lead", m), {31'd0, sclk_lead}, {31'd0, mode[1]});
      chk($sformatf("mode%0d_sclk_after", m), {31'd0, m_sclk}, {31'd0, mode[1]});
      chk($sformatf("mode%0d_mosi_bits", m), {24'd0, mbits[7:0]}, 32'h96);
    end
    loop = 1'b1;

    // LSB first
    go(1'b0, 16'h0001, 2'd0, MODE0, 1'b1, 1'b0);
    wait_done(1'b0, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
    chk("lsb_mosi_bits", {24'd0, mbits[7:0]}, 32'h80);
    chk("lsb_rx", {16'd0, m_rx}, 32'h01);

    // start pulsed again while busy is ignored
    go(1'b0, 16'h0033, 2'd0, MODE0, 1'b0, 1'b0);
    wait_done(1'b1, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
    chk("repulse_latency", 32'(lat), 32'd37);
    chk("repulse_rx", {16'd0, m_rx}, 32'h33);
    quiet(50, nb, nd);
    chk("repulse_busy_after", 32'(nb), 32'd0);
    chk("repulse_done_after", 32'(nd), 32'd0);

    // start held through DONE: back-to-back with one CS-high cycle
    go(1'b0, 16'h005A, 2'd0, MODE0, 1'b0, 1'b1);
    wait_done(1'b0, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
    chk("b2b_latency1", 32'(lat), 32'd37);
    chk("b2b_cs_done", {29'd0, m_cs}, 32'h7);
    @(negedge clk);
    chk("b2b_cs_next", {29'd0, m_cs}, 32'h6);
    chk("b2b_busy_next", {31'd0, m_busy}, 32'd1);
    start8  = 1'b0;
    tx_data = 16'h0000;
    wait_done(1'b0, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
    chk("b2b_latency2", 32'(lat), 32'd37);
    chk("b2b_rx", {16'd0, m_rx}, 32'h5A);

    // Asynchronous reset mid-transfer
    go(1'b0, 16'h00FF, 2'd0, MODE2, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_rx",   {24'd0, rx8},   32'd0);
    chk("abort_sclk", {31'd0, sclk8}, 32'd0);
    chk("abort_mosi", {31'd0, mosi8}, 32'd0);
    chk("abort_csn",  {30'd0, csn8},  32'h3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    quiet(60, nb, nd);
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_rx_held", {24'd0, rx8}, 32'd0);

    // 16-bit, CLK_DIV=1 instance
    go(1'b1, 16'hBEEF, 2'd0, MODE0, 1'b0, 1'b0);
    wait_done(1'b0, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
    chk("w16_latency", 32'(lat), 32'd35);
    chk("w16_rx", {16'd0, m_rx}, 32'hBEEF);
    chk("w16_cs", {29'd0, cs_mid}, 32'h6);

    // Out-of-range select: no CS asserted, transfer still completes
    go(1'b1, 16'h1234, 2'd3, MODE0, 1'b0, 1'b0);
    wait_done(1'b0, lat, rises, mbits, cs_mid, sclk_lead, cs_and);
    chk("oor_cs_never_low", {29'd0, cs_and}, 32'h7);
    chk("oor_latency", 32'(lat), 32'd35);
    chk("oor_rx", {16'd0, m_rx}, 32'h1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
